// File: rtl/test_tone_gen.sv
// test_tone_gen: multi-channel DDS audio test tone source.
//   Each channel owns a phase accumulator, a phase increment and a waveform
//   mode (0 sine, 1 square, 2 sawtooth, 3 mute). On every en pulse a small
//   FSM walks the channels one per cycle through a single shared quarter-wave
//   sine ROM. It then raises valid for one cycle once the whole sample set
//   is on data.
// Ports:
//   clk        system clock
//   reset_n    asynchronous active-low reset
//   en         sample enable pulse; starts one sample set
//   phase_clr  synchronous clear of every phase accumulator
//   cfg_we     configuration write strobe (cfg_ch, cfg_inc, cfg_mode)
//   data       packed samples, channel c at [c*WIDTH +: WIDTH]
//   valid      one-cycle pulse when a complete sample set is on data
//   overrun    sticky: en arrived while a sample set was in progress
// Build option: TEST_TONE_GEN_DITHER_EN adds a 16-bit LFSR whose LSB is
//   XORed into bit 0 of every non-mute sample.
module test_tone_gen #(
  parameter int          WIDTH    = 16,
  parameter int          CHANNELS = 2,
  parameter int          PHASE_W  = 24,
  parameter int          LUT_AW   = 8,
  parameter int unsigned INC_RST  = 524288
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        en,
  input  logic                        phase_clr,
  input  logic                        cfg_we,
  input  logic [2:0]                  cfg_ch,
  input  logic [PHASE_W-1:0]          cfg_inc,
  input  logic [1:0]                  cfg_mode,
  output logic [CHANNELS*WIDTH-1:0]   data,
  output logic                        valid,
  output logic                        overrun
);

  localparam int CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int SNAP_W = (WIDTH > LUT_AW) ? WIDTH : LUT_AW;
  localparam int QA_W   = LUT_AW - 2;
  localparam int QN     = 1 << QA_W;
  localparam int AMP_I  = (1 << (WIDTH - 1)) - 1;
  localparam real PI    = 3.14159265358979323846;
  localparam logic [WIDTH-1:0] AMP     = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [CH_W-1:0]  CH_LAST = CH_W'(CHANNELS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                state_q, state_d;
  logic [CH_W-1:0]       ch_q, ch_d;
  logic [PHASE_W-1:0]    phase_q [CHANNELS];
  logic [PHASE_W-1:0]    phase_d [CHANNELS];
  logic [PHASE_W-1:0]    inc_q   [CHANNELS];
  logic [PHASE_W-1:0]    inc_d   [CHANNELS];
  logic [1:0]            mode_q  [CHANNELS];
  logic [1:0]            mode_d  [CHANNELS];
  logic [SNAP_W-1:0]     snap_q  [CHANNELS];
  logic [SNAP_W-1:0]     snap_d  [CHANNELS];
  logic [CHANNELS*WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  overrun_q, overrun_d;

  // Quarter-wave sine table, entry i = round(AMP*sin(2*pi*i/2^LUT_AW)).
  logic [WIDTH-1:0] rom [QN];
  for (genvar i = 0; i < QN; i++) begin : g_rom
    localparam int ROM_V = $rtoi($floor($itor(AMP_I) *
                           $sin(2.0 * PI * $itor(i) / $itor(4 * QN)) + 0.5));
    assign rom[i] = WIDTH'(ROM_V);
  end

`ifdef TEST_TONE_GEN_DITHER_EN
  logic [15:0] lfsr_q, lfsr_d;
`endif

  // Waveform of the channel currently addressed by ch_q.
  logic [SNAP_W-1:0] cur_snap;
  logic [1:0]        cur_mode;
  logic [LUT_AW-1:0] lut_p;
  logic [QA_W-1:0]   lut_idx;
  logic [WIDTH-1:0]  sine_mag;
  logic [WIDTH-1:0]  sine_val;
  logic [WIDTH-1:0]  sample;

  always_comb begin
    cur_snap = snap_q[ch_q];
    cur_mode = mode_q[ch_q];
    lut_p    = cur_snap[SNAP_W-1 -: LUT_AW];
    // Odd quadrants read the table mirrored (QN - idx); idx 0 there is the
    // peak, which lies one past the end of the table.
    lut_idx  = lut_p[LUT_AW-2] ? (QA_W'(0) - lut_p[QA_W-1:0]) : lut_p[QA_W-1:0];
    if (lut_p[LUT_AW-2] && (lut_p[QA_W-1:0] == '0)) sine_mag = AMP;
    else                                            sine_mag = rom[lut_idx];
    sine_val = lut_p[LUT_AW-1] ? (WIDTH'(0) - sine_mag) : sine_mag;
    case (cur_mode)
      2'd0:    sample = sine_val;
      2'd1:    sample = cur_snap[SNAP_W-1] ? (WIDTH'(0) - AMP) : AMP;
      2'd2:    sample = {~cur_snap[SNAP_W-1], cur_snap[SNAP_W-2 -: WIDTH-1]};
      default: sample = '0;
    endcase
`ifdef TEST_TONE_GEN_DITHER_EN
    if (cur_mode != 2'd3) sample[0] = sample[0] ^ lfsr_q[0];
`endif
  end

  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    phase_d   = phase_q;
    inc_d     = inc_q;
    mode_d    = mode_q;
    snap_d    = snap_q;
    data_d    = data_q;
    valid_d   = (state_q == DONE);
    overrun_d = overrun_q | (en & (state_q != IDLE));
`ifdef TEST_TONE_GEN_DITHER_EN
    lfsr_d    = lfsr_q;
    if (state_q == RUN)
      lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
`endif

    case (state_q)
      IDLE: begin
        if (en) begin
          state_d = RUN;
          ch_d    = '0;
          // The waveform bits are captured on the en edge so that a
          // coincident phase_clr cannot alter the set being generated.
          for (int unsigned c = 0; c < CHANNELS; c++)
            snap_d[c] = phase_q[c][PHASE_W-1 -: SNAP_W];
        end
      end
      RUN: begin
        data_d[ch_q*WIDTH +: WIDTH] = sample;
        if (ch_q == CH_LAST) state_d = DONE;
        else                 ch_d    = ch_q + 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    for (int unsigned c = 0; c < CHANNELS; c++) begin
      if (cfg_we && (cfg_ch == 3'(c))) begin
        inc_d[c]  = cfg_inc;
        mode_d[c] = cfg_mode;
      end
      if ((state_q == RUN) && (ch_q == CH_W'(c)))
        phase_d[c] = phase_q[c] + inc_q[c];
      if (phase_clr)
        phase_d[c] = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      ch_q      <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        phase_q[c] <= '0;
        inc_q[c]   <= PHASE_W'(INC_RST);
        mode_q[c]  <= 2'd0;
        snap_q[c]  <= '0;
      end
`ifdef TEST_TONE_GEN_DITHER_EN
      lfsr_q    <= 16'hACE1;
`endif
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      phase_q   <= phase_d;
      inc_q     <= inc_d;
      mode_q    <= mode_d;
      snap_q    <= snap_d;
`ifdef TEST_TONE_GEN_DITHER_EN
      lfsr_q    <= lfsr_d;
`endif
    end
  end

  assign data    = data_q;
  assign valid   = valid_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_test_tone_gen.sv
// Bench for test_tone_gen: table of hand-derived vectors, directed corner
// sequences and randomized configuration checked against an arithmetic model.
module tb_test_tone_gen;
  localparam int          W       = 16;
  localparam int          NCH     = 2;
  localparam int          PW      = 24;
  localparam int          LA      = 8;
  localparam int unsigned INC_DEF = 524288;
  localparam int unsigned PMASK   = (1 << PW) - 1;
  localparam int          AMP     = (1 << (W - 1)) - 1;
  localparam real         PI      = 3.14159265358979323846;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              en;
  logic              phase_clr;
  logic              cfg_we;
  logic [2:0]        cfg_ch;
  logic [PW-1:0]     cfg_inc;
  logic [1:0]        cfg_mode;
  logic [NCH*W-1:0]  data;
  logic              valid;
  logic              overrun;

  int n_checks = 0;
  int n_errors = 0;

  int unsigned m_ph   [NCH];
  int unsigned m_inc  [NCH];
  int          m_mode [NCH];

  test_tone_gen #(
    .WIDTH(W), .CHANNELS(NCH), .PHASE_W(PW), .LUT_AW(LA), .INC_RST(INC_DEF)
  ) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .phase_clr(phase_clr),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_inc(cfg_inc), .cfg_mode(cfg_mode),
    .data(data), .valid(valid), .overrun(overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic int slot(input int c);
    return int'($signed(data[c*W +: W]));
  endfunction

  // Reference waveform computed directly from the phase value.
  function automatic int ref_wave(input int unsigned ph, input int m);
    real r;
    int  p;
    case (m)
      0: begin
        p = int'(ph >> (PW - LA));
        r = $itor(AMP) * $sin(2.0 * PI * $itor(p) / $itor(1 << LA));
        if (r >= 0.0) return $rtoi(r + 0.5);
        else          return -$rtoi(0.5 - r);
      end
      1:       return ((ph >> (PW - 1)) != 0) ? -AMP : AMP;
      2:       return int'(ph >> (PW - W)) - (1 << (W - 1));
      default: return 0;
    endcase
  endfunction

  task automatic m_reset();
    for (int c = 0; c < NCH; c++) begin
      m_ph[c] = 0; m_inc[c] = INC_DEF; m_mode[c] = 0;
    end
  endtask

  task automatic do_reset();
    en = 0; phase_clr = 0; cfg_we = 0; cfg_ch = 0; cfg_inc = 0; cfg_mode = 0;
    reset_n = 0;
    step(); step();
    reset_n = 1;
    step();
    m_reset();
  endtask

  task automatic write_cfg(input int ch, input int unsigned inc, input int mode);
    cfg_we = 1; cfg_ch = 3'(ch); cfg_inc = PW'(inc); cfg_mode = 2'(mode);
    step();
    cfg_we = 0;
    if (ch < NCH) begin
      m_inc[ch] = inc & PMASK; m_mode[ch] = mode;
    end
  endtask

  task automatic clear_phase();
    phase_clr = 1;
    step();
    phase_clr = 0;
    for (int c = 0; c < NCH; c++) m_ph[c] = 0;
  endtask

  // One en pulse (optionally with coincident phase_clr); checks latency,
  // samples against the model and that valid lasts one cycle.
  task automatic run_sample(input bit clr);
    int lat;
    int e [NCH];
    for (int c = 0; c < NCH; c++) begin
      e[c] = ref_wave(m_ph[c], m_mode[c]);
      m_ph[c] = ((clr ? 0 : m_ph[c]) + m_inc[c]) & PMASK;
    end
    en = 1; phase_clr = clr;
    step();
    en = 0; phase_clr = 0;
    lat = 0;
    while (valid !== 1'b1 && lat < 20) begin
      step();
      lat++;
    end
    check("valid_latency", lat, NCH + 1);
    for (int c = 0; c < NCH; c++)
      check($sformatf("sample_ch%0d", c), slot(c), e[c]);
    step();
    check("valid_one_cycle", valid, 0);
  endtask

  typedef struct {
    bit          clr;
    int          wr_ch;
    int unsigned wr_inc;
    int          wr_mode;
    int          exp0;
    int          exp1;
  } vec_t;

  vec_t vecs [11];

  initial begin
    int nv;
    int e0;

    vecs[0]  = '{0, 5, 123,     3, 0,      0};
    vecs[1]  = '{1, 0, 4194304, 0, 0,      0};
    vecs[2]  = '{0, 1, 8388608, 1, 32767,  32767};
    vecs[3]  = '{0, 5, 0,       2, 0,      -32767};
    vecs[4]  = '{0, 6, 0,       2, -32767, 32767};
    vecs[5]  = '{0, 7, 0,       2, 0,      -32767};
    vecs[6]  = '{0, 1, 0,       2, 32767,  -30720};
    vecs[7]  = '{1, 0, 4194304, 3, 0,      -32768};
    vecs[8]  = '{0, 5, 77,      1, 0,      -32768};
    vecs[9]  = '{0, 0, 4194304, 2, 0,      -32768};
    vecs[10] = '{0, 0, 4194304, 1, -32767, -32768};

    en = 0; phase_clr = 0; cfg_we = 0; cfg_ch = 0; cfg_inc = 0; cfg_mode = 0;
    reset_n = 0;
    step();
    check("reset_data", data, 0);
    check("reset_valid", valid, 0);
    check("reset_overrun", overrun, 0);
    do_reset();

    // First sample set after reset.
    run_sample(0);
    check("first_slot0", slot(0), 0);
    check("first_slot1", slot(1), 0);
    check("first_overrun", overrun, 0);

    // Table-driven vectors.
    do_reset();
    for (int i = 0; i < 11; i++) begin
      if (vecs[i].clr) clear_phase();
      write_cfg(vecs[i].wr_ch, vecs[i].wr_inc, vecs[i].wr_mode);
      run_sample(0);
      check($sformatf("vec%0d_ch0", i), slot(0), vecs[i].exp0);
      check($sformatf("vec%0d_ch1", i), slot(1), vecs[i].exp1);
    end

    // Default increment: one full period over 32 samples.
    do_reset();
    for (int k = 0; k <= 32; k++) begin
      run_sample(0);
      if (k == 8)  check("period_s8",  slot(0), 32767);
      if (k == 24) check("period_s24", slot(1), -32767);
      if (k == 32) check("period_s32", slot(0), 0);
    end

    // en during RUN: ignored, overrun sticky until reset.
    do_reset();
    e0 = ref_wave(m_ph[0], m_mode[0]);
    for (int c = 0; c < NCH; c++) m_ph[c] = (m_ph[c] + m_inc[c]) & PMASK;
    en = 1;
    step();
    step();
    en = 0;
    nv = 0;
    for (int i = 0; i < 15; i++) begin
      if (valid === 1'b1) nv++;
      step();
    end
    check("overrun_valid_count", nv, 1);
    check("overrun_set", overrun, 1);
    check("overrun_slot0", slot(0), e0);
    run_sample(0);
    check("overrun_sticky", overrun, 1);
    do_reset();
    check("overrun_cleared", overrun, 0);

    // Asynchronous reset in the middle of RUN.
    write_cfg(0, 0, 1);
    en = 1;
    step();
    en = 0;
    step();
    check("midrun_slot0", slot(0), 32767);
    reset_n = 0;
    #1;
    check("midrun_rst_data", data, 0);
    check("midrun_rst_valid", valid, 0);
    step(); step();
    reset_n = 1;
    m_reset();
    nv = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (valid === 1'b1) nv++;
    end
    check("midrun_no_valid", nv, 0);
    check("midrun_data_zero", data, 0);

    // phase_clr coincident with en.
    do_reset();
    write_cfg(0, 4194304, 0);
    write_cfg(1, 8388608 + 1234, 2);
    run_sample(0);
    run_sample(1);
    check("clr_en_preclear", slot(0), 32767);
    run_sample(0);
    check("clr_en_restart", slot(0), 32767);

    // Randomized configuration, clears and sample sets.
    do_reset();
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0)
        write_cfg(int'($urandom_range(0, 7)), $urandom & PMASK,
                  int'($urandom_range(0, 3)));
      if ($urandom_range(0, 7) == 0) clear_phase();
      run_sample($urandom_range(0, 5) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
